// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and fetch state encodings
package if_fetch_pkg;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;
   localparam int BYTE_BUS      = 8;
   localparam int IC_INDEX_W_DEF = 6;

   localparam logic [INST_BUS-1:0] ZERO_WORD = 32'h0000_0000;
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [1:0] ST_LOOKUP  = 2'd0;
   localparam logic [1:0] ST_FILL    = 2'd1;
   localparam logic [1:0] ST_PRESENT = 2'd2;

endpackage

// File: rtl/if_icache.sv
// rtl/if_icache.sv - direct-mapped one-word-per-line instruction cache
module if_icache
   import if_fetch_pkg::*;
#(
   parameter int INDEX_W = IC_INDEX_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [INDEX_W-1:0]          rd_index,
   input  logic [INST_ADDR_BUS-INDEX_W-3:0] rd_tag,
   output logic                        hit,
   output logic [INST_BUS-1:0]         rd_data,
   input  logic                        we,
   input  logic [INDEX_W-1:0]          wr_index,
   input  logic [INST_ADDR_BUS-INDEX_W-3:0] wr_tag,
   input  logic [INST_BUS-1:0]         wr_data
);

   localparam int TAG_W = INST_ADDR_BUS - INDEX_W - 2;
   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0]    valid;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [INST_BUS-1:0] data_mem [LINES];

   // valid bits clear asynchronously so a reset mid-run forces every lookup to miss
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else if (we) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // tag and data arrays need no reset; they are qualified by valid
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   // combinational lookup so a hit can be presented on the following edge
   always_comb begin
      hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
      rd_data = data_mem[rd_index];
   end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with byte-wide refill and IF/ID handshake
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_BUS-1:0] START_PC   = 32'h0000_0000,
   parameter int                       IC_INDEX_W = IC_INDEX_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [5:0]               stall,
   input  logic                     branch_i,
   input  logic [INST_ADDR_BUS-1:0] branch_target_i,
   output logic                     mem_req_o,
   output logic [INST_ADDR_BUS-1:0] mem_addr_o,
   input  logic                     mem_rvalid_i,
   input  logic [BYTE_BUS-1:0]      mem_rdata_i,
   output logic                     get_inst,
   output logic [INST_ADDR_BUS-1:0] if_pc,
   output logic [INST_BUS-1:0]      if_inst
);

   localparam int TAG_W = INST_ADDR_BUS - IC_INDEX_W - 2;

   logic [INST_ADDR_BUS-1:0] pc;
   logic [1:0]               state;
   logic [1:0]               byte_cnt;
   logic [23:0]              buffer;

   logic                     ic_hit;
   logic [INST_BUS-1:0]      ic_data;
   logic                     ic_we;
   logic [INST_BUS-1:0]      fill_word;
   logic [IC_INDEX_W-1:0]    pc_index;
   logic [TAG_W-1:0]         pc_tag;
   logic                     last_byte;

   // only stall[1:0] concern this stage
   logic unused_stall;
   assign unused_stall = ^stall[5:2];

   // pc does not move during FILL, so it addresses both lookup and refill write
   always_comb begin
      pc_index  = pc[IC_INDEX_W+1:2];
      pc_tag    = pc[INST_ADDR_BUS-1:IC_INDEX_W+2];
      last_byte = (state == ST_FILL) && mem_rvalid_i && (byte_cnt == 2'd3);
      // a completed word is cached even when a redirect arrives on the same cycle
      ic_we     = last_byte;
      fill_word = {mem_rdata_i, buffer};
   end

   if_icache #(
      .INDEX_W (IC_INDEX_W)
   ) u_icache (
      .clk      (clk),
      .rst      (rst),
      .rd_index (pc_index),
      .rd_tag   (pc_tag),
      .hit      (ic_hit),
      .rd_data  (ic_data),
      .we       (ic_we),
      .wr_index (pc_index),
      .wr_tag   (pc_tag),
      .wr_data  (fill_word)
   );

   // fetch state machine; redirect overrides every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= START_PC;
         state      <= ST_LOOKUP;
         byte_cnt   <= 2'd0;
         buffer     <= '0;
         get_inst   <= 1'b0;
         if_pc      <= ZERO_WORD;
         if_inst    <= ZERO_WORD;
         mem_req_o  <= 1'b0;
         mem_addr_o <= ZERO_WORD;
      end else if (branch_i) begin
         pc        <= branch_target_i;
         get_inst  <= 1'b0;
         mem_req_o <= 1'b0;
         byte_cnt  <= 2'd0;
         state     <= ST_LOOKUP;
      end else begin
         case (state)
            ST_LOOKUP: begin
               if (stall[0] == NO_STOP) begin
                  if (ic_hit) begin
                     if_pc    <= pc;
                     if_inst  <= ic_data;
                     get_inst <= 1'b1;
                     state    <= ST_PRESENT;
                  end else begin
                     byte_cnt   <= 2'd0;
                     mem_req_o  <= 1'b1;
                     mem_addr_o <= pc;
                     state      <= ST_FILL;
                  end
               end
            end
            // FILL ignores stall[0] so the memory transaction always completes
            ST_FILL: begin
               if (mem_rvalid_i) begin
                  case (byte_cnt)
                     2'd0:    buffer[7:0]   <= mem_rdata_i;
                     2'd1:    buffer[15:8]  <= mem_rdata_i;
                     2'd2:    buffer[23:16] <= mem_rdata_i;
                     default: buffer        <= buffer;
                  endcase
                  if (last_byte) begin
                     byte_cnt  <= 2'd0;
                     mem_req_o <= 1'b0;
                     get_inst  <= 1'b1;
                     if_pc     <= pc;
                     if_inst   <= fill_word;
                     state     <= ST_PRESENT;
                  end else begin
                     byte_cnt   <= byte_cnt + 2'd1;
                     mem_addr_o <= pc + {30'd0, byte_cnt} + 32'd1;
                  end
               end
            end
            ST_PRESENT: begin
               if (stall[0] == NO_STOP && stall[1] == NO_STOP) begin
                  get_inst <= 1'b0;
                  pc       <= pc + 32'd4;
                  state    <= ST_LOOKUP;
               end
            end
            default: begin
               state <= ST_LOOKUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_rvalid_i;
   logic [7:0]  mem_rdata_i;
   logic        get_inst;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] W0   = 32'h0010_0513;
   localparam logic [31:0] W4   = 32'h0020_0593;
   localparam logic [31:0] W8   = 32'h0030_0613;
   localparam logic [31:0] W100 = 32'hDEAD_BEEF;
   localparam logic [31:0] W200 = 32'hCAFE_F00D;

   if_fetch #(
      .START_PC   (32'h0000_0000),
      .IC_INDEX_W (6)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .mem_req_o       (mem_req_o),
      .mem_addr_o      (mem_addr_o),
      .mem_rvalid_i    (mem_rvalid_i),
      .mem_rdata_i     (mem_rdata_i),
      .get_inst        (get_inst),
      .if_pc           (if_pc),
      .if_inst         (if_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // poll for a memory request with a bounded budget
   task automatic wait_req(input string tag);
      int k;
      k = 0;
      while (!mem_req_o && k < 10) begin
         cycle();
         k++;
      end
      check({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
   endtask

   // serve n bytes of word at base, one wait cycle before each byte
   task automatic serve(input string tag, input logic [31:0] base, input logic [31:0] word, input int n);
      wait_req(tag);
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, mem_addr_o, base + i);
         cycle();
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = word[8*i +: 8];
         cycle();
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = 8'h00;
      end
   endtask

   task automatic check_present(input string tag, input logic [31:0] pc, input logic [31:0] word);
      check({tag, "_get"},  {31'd0, get_inst}, 32'd1);
      check({tag, "_pc"},   if_pc, pc);
      check({tag, "_inst"}, if_inst, word);
   endtask

   // release stall[1] for exactly one edge so the held instruction is consumed once
   task automatic consume();
      stall = 6'b000000;
      cycle();
      stall = 6'b000010;
   endtask

   task automatic redirect(input logic [31:0] target);
      branch_i        = 1'b1;
      branch_target_i = target;
      cycle();
      branch_i        = 1'b0;
   endtask

   initial begin
      rst             = 1'b0;
      stall           = 6'b000010;
      branch_i        = 1'b0;
      branch_target_i = 32'h0;
      mem_rvalid_i    = 1'b0;
      mem_rdata_i     = 8'h00;

      // reset state
      cycle();
      cycle();
      check("rst_get",  {31'd0, get_inst}, 32'd0);
      check("rst_req",  {31'd0, mem_req_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_pc",   if_pc, 32'h0);
      check("rst_inst", if_inst, 32'h0);
      rst = 1'b1;

      // cold miss at START_PC
      cycle();
      check("cold_req_now", {31'd0, mem_req_o}, 32'd1);
      serve("cold", 32'h0, W0, 4);
      check_present("cold", 32'h0, W0);
      check("cold_req_drop", {31'd0, mem_req_o}, 32'd0);

      // consume, then redirect back to 0: must hit without requesting memory
      consume();
      check("cons0_get", {31'd0, get_inst}, 32'd0);
      redirect(32'h0);
      check("hit0_req_a", {31'd0, mem_req_o}, 32'd0);
      check("hit0_get_a", {31'd0, get_inst}, 32'd0);
      cycle();
      check("hit0_req_b", {31'd0, mem_req_o}, 32'd0);
      check_present("hit0", 32'h0, W0);

      // fetch pc=4 then hold it with stall[1] for 5 cycles
      consume();
      serve("f4", 32'h4, W4, 4);
      check_present("f4", 32'h4, W4);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_present($sformatf("hold%0d", i), 32'h4, W4);
      end
      consume();
      check("cons4_get", {31'd0, get_inst}, 32'd0);

      // partial fill of pc=8 cut by a redirect to 0x100
      serve("f8p", 32'h8, W8, 2);
      redirect(32'h100);
      check("br_req_drop", {31'd0, mem_req_o}, 32'd0);
      check("br_get", {31'd0, get_inst}, 32'd0);
      serve("f100", 32'h100, W100, 4);
      check_present("f100", 32'h100, W100);

      // line for 8 must still be invalid
      consume();
      redirect(32'h8);
      serve("f8", 32'h8, W8, 4);
      check_present("f8", 32'h8, W8);

      // 0x100 evicted 0x000 (same index): refetch of 0 misses
      consume();
      redirect(32'h0);
      serve("conf0", 32'h0, W0, 4);
      check_present("conf0", 32'h0, W0);

      // reset after 3 bytes of a fill at 0x200
      consume();
      redirect(32'h200);
      serve("f200p", 32'h200, W200, 3);
      check("midrst_req_pre", {31'd0, mem_req_o}, 32'd1);
      #1 rst = 1'b0;
      #1;
      check("midrst_req",  {31'd0, mem_req_o}, 32'd0);
      check("midrst_addr", mem_addr_o, 32'h0);
      check("midrst_get",  {31'd0, get_inst}, 32'd0);
      check("midrst_pc",   if_pc, 32'h0);
      check("midrst_inst", if_inst, 32'h0);
      cycle();
      rst = 1'b1;
      cycle();
      serve("rst0", 32'h0, W0, 4);
      check_present("rst0", 32'h0, W0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and fetches 32-bit instructions over the byte-wide memory-controller port.
- Holds a small direct-mapped instruction cache in front of that port.
- Presents each instruction to the IF/ID register through get_inst / if_pc / if_inst. Accepts branch redirects and pipeline stall.

Parameters:
- START_PC, 32'h0000_0000, PC value loaded on reset.
- IC_INDEX_W, 6, log2 of cache lines (64 one-word lines). Index = pc[IC_INDEX_W+1:2]; tag = pc[31:IC_INDEX_W+2].

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- stall  input  6  pipeline stall vector. stall[1]=1 means IF/ID not accepting this cycle.
- branch_i  input  1  redirect request, valid for one cycle.
- branch_target_i  input  32  redirect PC.
- mem_req_o  output  1  byte read request.
- mem_addr_o  output  32  byte address of the request.
- mem_rvalid_i  input  1  byte returned this cycle.
- mem_rdata_i  input  8  returned byte.
- get_inst  output  1  if_pc/if_inst hold a valid instruction.
- if_pc  output  32  PC of the presented instruction.
- if_inst  output  32  presented instruction word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- While rst=0, all state clears:
  - pc=START_PC; state=LOOKUP; byte_cnt=0.
  - All cache valid bits=0.
  - get_inst=0, if_pc=0, if_inst=0, mem_req_o=0, mem_addr_o=0.
  - This applies at any point, including mid-fetch; partial bytes are lost.
- All outputs are registered.
- States: LOOKUP, FILL, PRESENT.
- LOOKUP:
  - On a cache hit (valid & tag match on pc), load if_pc=pc and if_inst=line, set get_inst=1, go to PRESENT.
  - Hit-to-get_inst latency is 1 cycle.
  - On a miss, go to FILL with byte_cnt=0. mem_req_o=1 and mem_addr_o=pc from the next cycle.
- FILL:
  - mem_req_o stays 1 and mem_addr_o = pc + byte_cnt.
  - On mem_rvalid_i, store the byte into buffer[8*byte_cnt+7 : 8*byte_cnt] (little-endian) and increment byte_cnt.
  - On the 4th byte: drop mem_req_o, write the word to the cache line (set valid, write tag), present it (get_inst=1), and go to PRESENT.
  - Cycles without mem_rvalid_i are wait states with no timeout.
- PRESENT (valid/ready handshake):
  - get_inst, if_pc and if_inst stay stable while stall[1]=1.
  - On the first edge with stall[1]=0, the instruction is consumed: get_inst=0, pc=pc+4 (32-bit wrap, 0xFFFF_FFFC+4=0), go to LOOKUP.
  - Back-to-back hits therefore yield one instruction every 2 cycles.
- Redirect (branch_i=1), highest priority in every state:
  - pc=branch_target_i, get_inst=0, mem_req_o=0 on the next cycle, byte_cnt=0, go to LOOKUP.
  - A partially filled word is discarded and not written to the cache.
  - If the 4th byte arrives in the same cycle as branch_i, the completed word is still written to the cache but not presented.
  - branch_i together with stall[1]=1 still redirects; the held instruction is dropped.
- stall[0]=1 freezes the state machine and pc in LOOKUP and PRESENT only.
  - FILL continues collecting bytes so the memory controller transaction completes.
- Cache conflicts: a fill overwrites the line; there is no replacement policy. Self-modifying code is unsupported.

Decomposition:
- Shared defines header gets: InstAddrBus, InstBus, ZeroWord, Stop/NoStop, plus new ByteBus, IcIndexW and fetch state encodings.
- One natural sub-module: if_icache. It holds the valid, tag and data arrays, a combinational lookup port (hit, data) and a synchronous write port (we, addr, data), with asynchronous clear of the valid bits.

Test Plan:
- Cold miss at reset, bytes 0x13,0x05,0x10,0x00 returned with 1 wait cycle each -> mem_addr_o 0,1,2,3; get_inst=1 with if_pc=0, if_inst=0x0010_0513 one cycle after the last byte.
- Redirect to 0 after the fetch of pc=0 is consumed -> no mem_req_o; get_inst=1 one cycle later with if_inst=0x0010_0513 (hit).
- stall[1]=1 for 5 cycles while presenting pc=4 -> outputs stable for all 5 cycles; after release, exactly one consume and pc becomes 8.
- branch_i with target 0x100 after 2 of 4 bytes of pc=8 -> mem_req_o low the next cycle; next request is at 0x100; line for pc=8 stays invalid (a refetch of 8 misses).
- Conflict: fetch 0x000 then 0x100 (same index) -> refetch of 0x000 misses and issues 4 byte requests.
- rst low mid-FILL after 3 bytes -> outputs cleared immediately; after release, fetch restarts at START_PC with byte_cnt=0 and a cache miss.
